// File: rtl/seg7_scan_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_if
//   Host/decoder bundle for seg7_scan_controller.
//   The master modport is the host side (drives scan control and the value
//   store). The slave modport is the controller side (drives the decoder
//   value and the digit enables).
//
//   enable      host -> ctrl   1 = scan, 0 = idle with display dark
//   wr_en       host -> ctrl   value store write strobe
//   wr_addr     host -> ctrl   digit index to write (AW bits)
//   wr_data     host -> ctrl   3-bit value to store
//   bright      host -> ctrl   PWM brightness, only when SEG7_DIM_EN is defined
//   dec_val     ctrl -> host   registered decoder input {A,B,C}
//   dig_en      ctrl -> host   one-hot digit enable, active-high
//   frame_done  ctrl -> host   1-cycle pulse at the end of a frame
//
//   Optional feature macro: SEG7_DIM_EN
// -----------------------------------------------------------------------------
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  enable;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [2:0]            wr_data;
  logic [2:0]            dec_val;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  frame_done;
`ifdef SEG7_DIM_EN
  logic [2:0]            bright;

  modport master (
    output enable, wr_en, wr_addr, wr_data, bright,
    input  dec_val, dig_en, frame_done
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, bright,
    output dec_val, dig_en, frame_done
  );
`else
  modport master (
    output enable, wr_en, wr_addr, wr_data,
    input  dec_val, dig_en, frame_done
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data,
    output dec_val, dig_en, frame_done
  );
`endif
endinterface

// File: rtl/seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller
//   Time-multiplexes one shared 3-bit-input 7-segment decoder across
//   NUM_DIGITS common-cathode digits. Each digit slot is BLANK_CYC clocks with
//   every digit dark followed by SHOW_CYC clocks with the selected digit lit,
//   which keeps the previous digit's value from ghosting onto the next one.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high
//     bus   seg7_scan_if.slave (enable, wr_en/wr_addr/wr_data in;
//           dec_val, dig_en, frame_done out; bright in with SEG7_DIM_EN)
//
//   Optional feature macro: SEG7_DIM_EN
//     Defined   : bright is captured on entry to SHOW and gates dig_en as an
//                 8-step PWM (lit while cnt[2:0] <= bright).
//     Undefined : digit is lit for the whole SHOW phase.
// -----------------------------------------------------------------------------
module seg7_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_CYC  = 2,
  parameter int SHOW_CYC   = 16
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int AW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
  // At least 3 bits so the PWM compare can always look at cnt[2:0].
  localparam int CW   = ($clog2(MAXC) < 3) ? 3 : $clog2(MAXC);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [AW:0]   ADDR_LIM   = (AW + 1)'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state_p0, state_nxt;
  logic [AW-1:0]   idx_p0, idx_nxt;
  logic [CW-1:0]   cnt_p0, cnt_nxt;
  logic            dig_on;
  logic            frame_nxt;
  logic [2:0]      value [NUM_DIGITS];

  logic [2:0]            dec_val_p1;
  logic [NUM_DIGITS-1:0] dig_en_p1;
  logic                  frame_done_p1;

`ifdef SEG7_DIM_EN
  logic [2:0] bright_s;
`endif

  function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [AW-1:0] i);
    digit_sel = NUM_DIGITS'(1) << i;
  endfunction

  // ---- stage p0: scan FSM next-state / digit-on decision ----
  always_comb begin
    state_nxt = state_p0;
    idx_nxt   = idx_p0;
    cnt_nxt   = cnt_p0;
    dig_on    = 1'b0;
    frame_nxt = 1'b0;
    case (state_p0)
      IDLE: begin
        idx_nxt = '0;
        cnt_nxt = '0;
        if (bus.enable) state_nxt = BLANK;
      end
      BLANK: begin
        if (!bus.enable) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt_p0 == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_p0 + 1'b1;
        end
      end
      SHOW: begin
        if (!bus.enable) begin
          // Abort immediately: no partial-slot completion.
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
`ifdef SEG7_DIM_EN
          dig_on = (cnt_p0[2:0] <= bright_s);
`else
          dig_on = 1'b1;
`endif
          if (cnt_p0 == SHOW_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx_p0 == IDX_LAST) begin
              idx_nxt   = '0;
              frame_nxt = 1'b1;
            end else begin
              idx_nxt = idx_p0 + 1'b1;
            end
          end else begin
            cnt_nxt = cnt_p0 + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      idx_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      idx_p0   <= idx_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

`ifdef SEG7_DIM_EN
  // Brightness is frozen for the whole slot so a mid-slot change cannot
  // produce a truncated or stretched pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_s <= '0;
    end else if (state_p0 == BLANK && state_nxt == SHOW) begin
      bright_s <= bus.bright;
    end
  end
`endif

  // Value store: out-of-range addresses (non power-of-two digit counts) drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) value[i] <= '0;
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < ADDR_LIM)) begin
      value[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---- stage p1: registered decoder/digit outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_val_p1    <= '0;
      dig_en_p1     <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      dec_val_p1    <= value[idx_p0];
      dig_en_p1     <= dig_on ? digit_sel(idx_p0) : '0;
      frame_done_p1 <= frame_nxt;
    end
  end

  assign bus.dec_val    = dec_val_p1;
  assign bus.dig_en     = dig_en_p1;
  assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_controller
//   Bench for seg7_scan_controller with NUM_DIGITS=4 (dut_a) and NUM_DIGITS=3
//   (dut_b), BLANK_CYC=2, SHOW_CYC=4. Expected per-cycle outputs are derived
//   from the slot/frame timeline, queued when the stimulus starts, and popped
//   as the DUT produces each cycle. Dimming checks need SEG7_DIM_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_scan_controller;
  localparam int ND  = 4;
  localparam int ND3 = 3;
  localparam int BC  = 2;
  localparam int SC  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND))  ifa ();
  seg7_scan_if #(.NUM_DIGITS(ND3)) ifb ();

  seg7_scan_controller #(.NUM_DIGITS(ND), .BLANK_CYC(BC), .SHOW_CYC(SC)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  seg7_scan_controller #(.NUM_DIGITS(ND3), .BLANK_CYC(BC), .SHOW_CYC(SC)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct {
    logic [7:0] dig;
    logic [2:0] dec;
    logic       chk_dec;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   mval[8];

  // Expected outputs k cycles after the edge that sampled enable high in IDLE.
  function automatic exp_t model(int k, int nd, int br);
    exp_t e;
    int j, sl, slot, pos;
    e.dig = '0; e.dec = '0; e.chk_dec = 1'b0; e.fd = 1'b0;
    if (k >= 1) begin
      j    = k - 1;
      sl   = BC + SC;
      slot = (j / sl) % nd;
      pos  = j % sl;
      if (pos >= BC && ((pos - BC) % 8) <= br) begin
        e.dig     = 8'(1) << slot;
        e.dec     = 3'(mval[slot]);
        e.chk_dec = 1'b1;
      end
      if (j % (nd * sl) == nd * sl - 1) e.fd = 1'b1;
    end
    return e;
  endfunction

  task automatic push_exp(int k0, int k1, int nd, int br);
    for (int k = k0; k < k1; k++) sbq.push_back(model(k, nd, br));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(int addr, int data);
    ifa.wr_en = 1'b1; ifa.wr_addr = 2'(addr); ifa.wr_data = 3'(data);
    tick();
    ifa.wr_en = 1'b0;
    mval[addr] = data;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    ifa.enable = 1'b1; ifa.wr_en = 1'b1; ifa.wr_addr = 2'd0; ifa.wr_data = 3'd7;
    ifb.enable = 1'b1;
    tick(); tick();
    checks++; if (ifa.dig_en !== 4'b0) begin failures++; $display("FAIL reset_dig_en got=%b exp=0000", ifa.dig_en); end
    checks++; if (ifa.dec_val !== 3'd0) begin failures++; $display("FAIL reset_dec_val got=%0d exp=0", ifa.dec_val); end
    checks++; if (ifa.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", ifa.frame_done); end
    checks++; if (ifb.dig_en !== 3'b0) begin failures++; $display("FAIL reset_b_dig_en got=%b exp=000", ifb.dig_en); end
    rst = 1'b0; ifa.enable = 1'b0; ifa.wr_en = 1'b0; ifb.enable = 1'b0;
    tick();
    // Idle with enable low stays dark.
    e = model(0, ND, 7);
    checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL idle_dig_en got=%b exp=%b", ifa.dig_en, e.dig); end
  endtask

  task automatic test_scan();
    exp_t e;
    write_a(0, 5); write_a(1, 2); write_a(2, 7); write_a(3, 1);
    ifa.enable = 1'b1;
    push_exp(0, 60, ND, 7);
    for (int k = 0; k < 60; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL scan_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
      checks++; if (ifa.frame_done !== e.fd) begin failures++; $display("FAIL scan_frame_done k=%0d got=%b exp=%b", k, ifa.frame_done, e.fd); end
      if (e.chk_dec) begin
        checks++; if (ifa.dec_val !== e.dec) begin failures++; $display("FAIL scan_dec_val k=%0d got=%0d exp=%0d", k, ifa.dec_val, e.dec); end
      end
    end
    ifa.enable = 1'b0;
    tick();
  endtask

  task automatic test_write_shown();
    exp_t e;
    ifa.enable = 1'b1;
    // Write to digit 3 is driven after k=20, sampled at edge 21, visible at k=22.
    push_exp(0, 22, ND, 7);
    mval[3] = 6;
    push_exp(22, 41, ND, 7);
    for (int k = 0; k < 41; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL wr_shown_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
      if (e.chk_dec) begin
        checks++; if (ifa.dec_val !== e.dec) begin failures++; $display("FAIL wr_shown_dec_val k=%0d got=%0d exp=%0d", k, ifa.dec_val, e.dec); end
      end
      if (k == 20) begin
        ifa.wr_en = 1'b1; ifa.wr_addr = 2'd3; ifa.wr_data = 3'd6;
      end else if (k == 21) begin
        ifa.wr_en = 1'b0;
      end
    end
    ifa.enable = 1'b0;
    tick();
  endtask

  task automatic test_disable();
    exp_t e;
    ifa.enable = 1'b1;
    push_exp(0, 17, ND, 7);
    for (int k = 0; k < 17; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL dis_pre_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
    end
    // k=16 is mid-SHOW of digit 2; drop enable now.
    ifa.enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e.dig = '0; e.dec = '0; e.chk_dec = 1'b0; e.fd = 1'b0;
      sbq.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL dis_dark_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
      checks++; if (ifa.frame_done !== e.fd) begin failures++; $display("FAIL dis_dark_frame_done k=%0d got=%b exp=%b", k, ifa.frame_done, e.fd); end
    end
    ifa.enable = 1'b1;
    push_exp(0, 14, ND, 7);
    for (int k = 0; k < 14; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL reen_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
      if (e.chk_dec) begin
        checks++; if (ifa.dec_val !== e.dec) begin failures++; $display("FAIL reen_dec_val k=%0d got=%0d exp=%0d", k, ifa.dec_val, e.dec); end
      end
    end
    ifa.enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    ifa.enable = 1'b1;
    push_exp(0, 10, ND, 7);
    for (int k = 0; k < 10; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL rstmid_pre_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
    end
    rst = 1'b1; ifa.wr_en = 1'b1; ifa.wr_addr = 2'd0; ifa.wr_data = 3'd3;
    tick();
    checks++; if (ifa.dig_en !== 4'b0) begin failures++; $display("FAIL rstmid_dig_en got=%b exp=0000", ifa.dig_en); end
    checks++; if (ifa.dec_val !== 3'd0) begin failures++; $display("FAIL rstmid_dec_val got=%0d exp=0", ifa.dec_val); end
    checks++; if (ifa.frame_done !== 1'b0) begin failures++; $display("FAIL rstmid_frame_done got=%b exp=0", ifa.frame_done); end
    rst = 1'b0; ifa.wr_en = 1'b0; ifa.enable = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) mval[i] = 0;
    ifa.enable = 1'b1;
    push_exp(0, 30, ND, 7);
    for (int k = 0; k < 30; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL rstmid_post_dig_en k=%0d got=%b exp=%b", k, ifa.dig_en, e.dig); end
      if (e.chk_dec) begin
        checks++; if (ifa.dec_val !== e.dec) begin failures++; $display("FAIL rstmid_post_dec_val k=%0d got=%0d exp=%0d", k, ifa.dec_val, e.dec); end
      end
    end
    ifa.enable = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    exp_t e;
    int vals[4] = '{3, 4, 5, 7};
    for (int a = 0; a < 4; a++) begin
      ifb.wr_en = 1'b1; ifb.wr_addr = 2'(a); ifb.wr_data = 3'(vals[a]);
      tick();
    end
    ifb.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) mval[i] = 0;
    mval[0] = 3; mval[1] = 4; mval[2] = 5;
    ifb.enable = 1'b1;
    push_exp(0, 40, ND3, 7);
    for (int k = 0; k < 40; k++) begin
      tick();
      e = sbq.pop_front();
      checks++; if ({5'b0, ifb.dig_en} !== e.dig) begin failures++; $display("FAIL oor_dig_en k=%0d got=%b exp=%b", k, ifb.dig_en, e.dig); end
      checks++; if (ifb.frame_done !== e.fd) begin failures++; $display("FAIL oor_frame_done k=%0d got=%b exp=%b", k, ifb.frame_done, e.fd); end
      if (e.chk_dec) begin
        checks++; if (ifb.dec_val !== e.dec) begin failures++; $display("FAIL oor_dec_val k=%0d got=%0d exp=%0d", k, ifb.dec_val, e.dec); end
      end
    end
    ifb.enable = 1'b0;
    tick();
  endtask

`ifdef SEG7_DIM_EN
  task automatic test_dim();
    exp_t e;
    int br_tab[2] = '{1, 7};
    write_a(0, 5); write_a(1, 2); write_a(2, 7); write_a(3, 1);
    for (int t = 0; t < 2; t++) begin
      ifa.bright = 3'(br_tab[t]);
      ifa.enable = 1'b1;
      push_exp(0, 30, ND, br_tab[t]);
      for (int k = 0; k < 30; k++) begin
        tick();
        e = sbq.pop_front();
        checks++; if ({4'b0, ifa.dig_en} !== e.dig) begin failures++; $display("FAIL dim%0d_dig_en k=%0d got=%b exp=%b", br_tab[t], k, ifa.dig_en, e.dig); end
        checks++; if (ifa.frame_done !== e.fd) begin failures++; $display("FAIL dim%0d_frame_done k=%0d got=%b exp=%b", br_tab[t], k, ifa.frame_done, e.fd); end
      end
      ifa.enable = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.enable = 1'b0; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifb.enable = 1'b0; ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
`ifdef SEG7_DIM_EN
    ifa.bright = 3'd7;
    ifb.bright = 3'd7;
`endif
    for (int i = 0; i < 8; i++) mval[i] = 0;
    test_reset();
    test_scan();
    test_write_shown();
    test_disable();
    test_reset_midframe();
    test_out_of_range();
`ifdef SEG7_DIM_EN
    test_dim();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
